// File: rtl/rr_sel_pkg.sv
// Shared constants and types for the round-robin mux-select arbiter.
package rr_sel_pkg;
  localparam int NCH       = 4;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 15;
  localparam int DW_W      = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } st_e;

  function automatic logic [NCH-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester searching upward from last+1.
module rr_pick4
  import rr_sel_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [1:0]     last,
  output logic [1:0]     idx,
  output logic           any
);
  logic [1:0] ch;

  // Walk the search order backwards so the earliest requester wins the last write.
  always_comb begin
    idx = '0;
    ch  = '0;
    any = |req;
    for (int i = NCH - 1; i >= 0; i--) begin
      ch = last + 2'(i + 1);
      if (req[ch]) idx = ch;
    end
  end
endmodule

// File: rtl/rr_sel4.sv
// Round-robin select generator for a 4:1 mux: grant, dwell, then ready/valid offer.
module rr_sel4
  import rr_sel_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [NCH-1:0]   grant,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output st_e              state
);
  // Handshake: a transfer completes at a rising edge where out_valid && out_ready.
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_dwell_range
    $error("rr_sel4: DWELL must be within 1..15");
  end

  logic [1:0]      last;
  logic [DW_W-1:0] dwell_cnt;
  logic [1:0]      pick_idx;
  logic            pick_any;
  logic            hs;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign out_valid = (state == ST_GRANT) && (dwell_cnt == DWELL_LAST);
  assign busy      = (state == ST_GRANT);
  assign hs        = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= '0;
      grant     <= '0;
      last      <= 2'd3;
      dwell_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            sel       <= pick_idx;
            grant     <= onehot4(pick_idx);
            dwell_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A handshake takes priority over a simultaneous request drop.
          if (hs) begin
            last     <= sel;
            grant    <= '0;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
            state    <= ST_IDLE;
          end else if (!req[sel]) begin
            last  <= sel;
            grant <= '0;
            state <= ST_IDLE;
          end else if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_sel4.sv
// Bench for rr_sel4: directed table, hand sequences, and random traffic against a model.
module tb_rr_sel4;
  import rr_sel_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] sel_a, sel_b;
  logic [3:0] grant_a, grant_b;
  logic       ov_a, ov_b, busy_a, busy_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  st_e        st_a, st_b;

  always #5 clk = ~clk;

  rr_sel4 #(.DWELL(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_a), .grant(grant_a), .out_valid(ov_a), .busy(busy_a),
    .xfer_cnt(cnt_a), .state(st_a)
  );

  rr_sel4 #(.DWELL(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_b), .grant(grant_b), .out_valid(ov_b), .busy(busy_b),
    .xfer_cnt(cnt_b), .state(st_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, one slot per instance: [0] DWELL=2/8-bit, [1] DWELL=1/2-bit.
  int m_dw[2]  = '{2, 1};
  int m_mod[2] = '{256, 4};
  int m_busy[2], m_ch[2], m_sel[2], m_age[2], m_last[2], m_cnt[2];

  function automatic void m_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_ch[m] = 0; m_sel[m] = 0;
      m_age[m] = 0; m_last[m] = 3; m_cnt[m] = 0;
    end
  endfunction

  function automatic int m_valid(input int m);
    return (m_busy[m] != 0 && m_age[m] >= m_dw[m] - 1) ? 1 : 0;
  endfunction

  function automatic void m_clock();
    int found;
    int c;
    if (!rst_n) begin
      m_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (m_busy[m] != 0) begin
        if (m_valid(m) != 0 && out_ready) begin
          m_cnt[m]  = (m_cnt[m] + 1) % m_mod[m];
          m_last[m] = m_ch[m];
          m_busy[m] = 0;
        end else if (!req[m_ch[m]]) begin
          m_last[m] = m_ch[m];
          m_busy[m] = 0;
        end else begin
          m_age[m]++;
        end
      end else if (req != 4'b0000) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last[m] + k) % 4;
          if (found == 0 && req[c]) begin
            found = 1;
            m_ch[m] = c; m_sel[m] = c; m_age[m] = 0; m_busy[m] = 1;
          end
        end
      end
    end
  endfunction

  task automatic check_model();
    chk("a.grant", grant_a, m_busy[0] != 0 ? (32'd1 << m_ch[0]) : 32'd0);
    chk("a.sel",   sel_a,   m_sel[0]);
    chk("a.valid", ov_a,    m_valid(0));
    chk("a.busy",  busy_a,  m_busy[0]);
    chk("a.cnt",   cnt_a,   m_cnt[0]);
    chk("a.state", st_a,    m_busy[0] != 0 ? ST_GRANT : ST_IDLE);
    chk("b.grant", grant_b, m_busy[1] != 0 ? (32'd1 << m_ch[1]) : 32'd0);
    chk("b.sel",   sel_b,   m_sel[1]);
    chk("b.valid", ov_b,    m_valid(1));
    chk("b.busy",  busy_b,  m_busy[1]);
    chk("b.cnt",   cnt_b,   m_cnt[1]);
  endtask

  task automatic step();
    @(posedge clk);
    m_clock();
    #1;
    check_model();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_model();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       ov;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[13];
  int   wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Round-robin with all requesters, DWELL=2: one transfer every 3 cycles.
    tbl[0]  = '{4'hf, 1'b1, 4'b0001, 2'd0, 1'b0, 8'd0};
    tbl[1]  = '{4'hf, 1'b1, 4'b0001, 2'd0, 1'b1, 8'd0};
    tbl[2]  = '{4'hf, 1'b1, 4'b0000, 2'd0, 1'b0, 8'd1};
    tbl[3]  = '{4'hf, 1'b1, 4'b0010, 2'd1, 1'b0, 8'd1};
    tbl[4]  = '{4'hf, 1'b1, 4'b0010, 2'd1, 1'b1, 8'd1};
    tbl[5]  = '{4'hf, 1'b1, 4'b0000, 2'd1, 1'b0, 8'd2};
    tbl[6]  = '{4'hf, 1'b1, 4'b0100, 2'd2, 1'b0, 8'd2};
    tbl[7]  = '{4'hf, 1'b1, 4'b0100, 2'd2, 1'b1, 8'd2};
    tbl[8]  = '{4'hf, 1'b1, 4'b0000, 2'd2, 1'b0, 8'd3};
    tbl[9]  = '{4'hf, 1'b1, 4'b1000, 2'd3, 1'b0, 8'd3};
    tbl[10] = '{4'hf, 1'b1, 4'b1000, 2'd3, 1'b1, 8'd3};
    tbl[11] = '{4'hf, 1'b1, 4'b0000, 2'd3, 1'b0, 8'd4};
    tbl[12] = '{4'hf, 1'b1, 4'b0001, 2'd0, 1'b0, 8'd4};

    req = 4'h0;
    out_ready = 1'b0;
    assert_reset();
    chk("rst.grant", grant_a, 0);
    chk("rst.sel",   sel_a,   0);
    repeat (2) step();

    req = tbl[0].req;
    out_ready = tbl[0].rdy;
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      out_ready = tbl[i].rdy;
      step();
      chk("tbl.grant", grant_a, tbl[i].grant);
      chk("tbl.sel",   sel_a,   tbl[i].sel);
      chk("tbl.valid", ov_a,    tbl[i].ov);
      chk("tbl.cnt",   cnt_a,   tbl[i].cnt);
    end

    // Reset while dut_a holds a grant: everything clears without a clock edge.
    assert_reset();
    chk("midrst.grant", grant_a, 0);
    chk("midrst.valid", ov_a,    0);
    chk("midrst.busy",  busy_a,  0);
    chk("midrst.cnt",   cnt_a,   0);
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("midrst.prio", grant_a, 4'b0001);
    req = 4'h0;
    step();
    chk("abort0.busy", busy_a, 0);

    // Backpressure on channel 2.
    req = 4'b0100;
    step();
    chk("bp.grant", grant_a, 4'b0100);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp.sel",   sel_a, 2);
      chk("bp.valid", ov_a,  1);
    end
    out_ready = 1'b1;
    step();
    chk("bp.cnt", cnt_a, 1);
    out_ready = 1'b0;

    // Abort of channel 1 before out_valid; channel 2 is next.
    req = 4'b0110;
    step();
    chk("abort.grant", grant_a, 4'b0010);
    req = 4'b0100;
    step();
    chk("abort.busy", busy_a, 0);
    chk("abort.cnt",  cnt_a,  1);
    step();
    chk("abort.next", grant_a, 4'b0100);

    // Request drop coinciding with the handshake still counts.
    step();
    chk("simul.valid", ov_a, 1);
    req = 4'b0000;
    out_ready = 1'b1;
    step();
    chk("simul.cnt",  cnt_a,  2);
    chk("simul.busy", busy_a, 0);

    // Counter wrap on the 2-bit instance.
    assert_reset();
    step();
    rst_n = 1'b1;
    req = 4'b0001;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      step();
      chk("wrap.cnt", cnt_b, wrap_exp[i]);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 79) == 0) begin
        assert_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
